ofifo_drain_ctrl: RTL
=====================

OFIFO_DRAIN_CTRL -- requirements
Module: ofifo_drain_ctrl

Interface
REQ-001 SHALL have parameter col, default 8, number of output-FIFO lanes.
REQ-002 SHALL have parameter bw, default 16, bits per lane.
REQ-003 SHALL have parameter ADDR_W, default 11, psum SRAM address width.
REQ-004 SHALL have parameter RD_LAT, default 1, cycles from ofifo_rd to valid ofifo_out, legal range 1..4.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-006 SHALL have ports:
 start  in  1  one-cycle pulse, begin a drain job
 num_vec  in  ADDR_W  vectors to drain, sampled on accepted start
 base_addr  in  ADDR_W  first SRAM address, sampled on accepted start
 ofifo_valid  in  1  all FIFO lanes non-empty
 ofifo_full  in  1  any FIFO lane full
 ofifo_out  in  bw*col  FIFO head vector
 ofifo_rd  out  1  FIFO read request
 sram_wen  out  1  SRAM write enable, active-high
 sram_addr  out  ADDR_W  SRAM write address
 sram_din  out  bw*col  SRAM write data
 busy  out  1  high outside IDLE
 done  out  1  one-cycle job-complete pulse
 overflow  out  1  sticky, ofifo_full seen while busy

Function
REQ-007 SHALL implement FSM IDLE, DRAIN, FLUSH, DONE; busy = (state != IDLE).
REQ-008 SHALL leave IDLE only on start; start outside IDLE ignored.
REQ-009 SHALL on accepted start with num_vec != 0 latch num_vec/base_addr, clear counters, go to DRAIN; with num_vec == 0 go directly to DONE.
REQ-010 SHALL in DRAIN assert ofifo_rd in cycle t only if ofifo_valid is high in t, ofifo_rd was low in t-1, and issued count < latched num_vec (max one read per two cycles, covering the FIFO's registered read enable).
REQ-011 SHALL keep ofifo_rd combinationally derived from registered state and ofifo_valid, never high outside DRAIN.
REQ-012 SHALL track each issued read in an RD_LAT-deep valid shift register and capture ofifo_out in cycle t+RD_LAT.
REQ-013 SHALL register the write: sram_wen high in cycle t+RD_LAT+1 with sram_din = captured vector and sram_addr = (base_addr + written count) mod 2^ADDR_W, then increment written count.
REQ-014 SHALL go DRAIN -> FLUSH in the cycle after issued count reaches num_vec.
REQ-015 SHALL go FLUSH -> DONE when written count reaches num_vec and the shift register is empty.
REQ-016 SHALL in DONE assert done for exactly one cycle, then go to IDLE; a start in the DONE cycle is ignored.
REQ-017 SHALL set overflow when ofifo_full is high while busy; cleared only by reset or accepted start.
REQ-018 SHALL hold sram_wen low and sram_addr/sram_din stable when no write is pending.

Reset
REQ-019 SHALL on reset, including mid-job, force state IDLE, counters and shift register 0, ofifo_rd, sram_wen, done, overflow low, sram_addr and sram_din 0, in the next cycle.
REQ-020 SHALL discard any in-flight read data on reset; no SRAM write follows reset.

Configuration
REQ-021 SHALL, with macro OFIFO_DRAIN_RELU_EN defined, replace each signed bw-bit lane of the captured vector with 0 when negative before writing sram_din.
REQ-022 SHALL, without OFIFO_DRAIN_RELU_EN, write the captured vector unmodified; timing identical in both builds.

Verification
REQ-023 SHALL cover: start, num_vec=4, base_addr=10, ofifo_valid held high -> rd at 4 cycles spaced 2 apart, writes to 10..13 in order, done pulse once, busy falls next cycle.
REQ-024 SHALL cover: num_vec=3, base_addr=2046 (ADDR_W=11) -> writes at 2046, 2047, 0.
REQ-025 SHALL cover: num_vec=0 -> no rd, no wen, done one cycle after start.
REQ-026 SHALL cover: ofifo_valid toggled low for 5 cycles mid-job -> no rd while low, job completes with exact num_vec writes.
REQ-027 SHALL cover: reset asserted one cycle after second rd of num_vec=6 -> all outputs 0 next cycle, no further wen; new start then runs normally.
REQ-028 SHALL cover: lane value 0xFFF0 with macro defined -> written 0x0000; without macro -> 0xFFF0; ofifo_full pulse while busy -> overflow stays high until next start.

Source files
------------

// File: rtl/ofifo_drain_ctrl.sv
// ofifo_drain_ctrl
//   Drains a job of num_vec vectors from the output FIFO into the psum SRAM.
//   Reads are spaced at least two cycles apart so the FIFO's registered read
//   enable never sees back-to-back requests. Each read is tracked through an
//   RD_LAT-deep valid pipe. The returned vector is captured RD_LAT cycles
//   after the read and written to base_addr + n (wrapping) one cycle later.
//
//   Build option: define OFIFO_DRAIN_RELU_EN to clamp negative signed lanes
//   of each captured vector to zero before the SRAM write. Timing is the
//   same with or without the option.
//
//   Ports
//     clk, reset   rising-edge clock, synchronous active-high reset
//     start        one-cycle pulse, accepted only in IDLE
//     num_vec      vectors to drain (latched on accepted start)
//     base_addr    first SRAM address (latched on accepted start)
//     ofifo_valid  all FIFO lanes non-empty
//     ofifo_full   any FIFO lane full
//     ofifo_out    FIFO head vector
//     ofifo_rd     FIFO read request (combinational)
//     sram_wen     SRAM write enable
//     sram_addr    SRAM write address
//     sram_din     SRAM write data
//     busy         high outside IDLE
//     done         one-cycle job-complete pulse
//     overflow     sticky: ofifo_full seen while busy
module ofifo_drain_ctrl #(
   parameter int col    = 8,
   parameter int bw     = 16,
   parameter int ADDR_W = 11,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   num_vec,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic                ofifo_valid,
   input  logic                ofifo_full,
   input  logic [bw*col-1:0]   ofifo_out,
   output logic                ofifo_rd,
   output logic                sram_wen,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [bw*col-1:0]   sram_din,
   output logic                busy,
   output logic                done,
   output logic                overflow
);

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   vec_n;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W-1:0]   issued;
   logic [ADDR_W-1:0]   written;
   logic [RD_LAT-1:0]   vld_sr;
   logic [bw*col-1:0]   wr_data;
   logic                cap;

   // Read data is on ofifo_out while the oldest pipe stage is set.
   assign cap = vld_sr[RD_LAT-1];

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (num_vec == '0) ? DONE : DRAIN;
         DRAIN:   if (issued == vec_n) state_nx = FLUSH;
         FLUSH:   if ((written == vec_n) && (vld_sr == '0)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs; vld_sr[0] is last cycle's ofifo_rd, which enforces the
   // one-read-per-two-cycles spacing.
   always_comb begin
      busy     = (state != IDLE);
      done     = (state == DONE);
      ofifo_rd = (state == DRAIN) && ofifo_valid && !vld_sr[0] && (issued < vec_n);
   end

   always_comb begin
      wr_data = ofifo_out;
`ifdef OFIFO_DRAIN_RELU_EN
      for (int unsigned l = 0; l < col; l++) begin
         if (ofifo_out[l*bw + bw - 1]) wr_data[l*bw +: bw] = '0;
      end
`endif
   end

   // Datapath: capture and SRAM write register share one stage, so the
   // write appears the cycle after the capture edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_sr    <= '0;
         vec_n     <= '0;
         base_q    <= '0;
         issued    <= '0;
         written   <= '0;
         sram_wen  <= 1'b0;
         sram_addr <= '0;
         sram_din  <= '0;
         overflow  <= 1'b0;
      end else begin
         vld_sr[0] <= ofifo_rd;
         for (int unsigned i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];

         sram_wen <= cap;
         if (cap) begin
            sram_din  <= wr_data;
            sram_addr <= base_q + written;
            written   <= written + 1'b1;
         end

         if (ofifo_rd) issued <= issued + 1'b1;

         if ((state == IDLE) && start) begin
            vec_n    <= num_vec;
            base_q   <= base_addr;
            issued   <= '0;
            written  <= '0;
            overflow <= 1'b0;
         end else if (ofifo_full && busy) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule
